// File: rtl/adc_capture_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture_buffer_pkg
//  Description : Shared FSM state encoding, default sample width and the
//                parameter legality helper for the ADC capture buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package adc_capture_buffer_pkg;

  localparam int c_default_data_w = 12;
  localparam int c_state_w        = 2;

  typedef logic [c_state_w-1:0] state_t;

  localparam state_t c_st_idle = 2'd0;
  localparam state_t c_st_pre  = 2'd1;
  localparam state_t c_st_post = 2'd2;
  localparam state_t c_st_play = 2'd3;

  // True when the RAM size is a power of two matching the address width and
  // the whole trigger window fits inside the RAM.
  function automatic bit params_legal(input int depth, input int addr_w,
                                      input int pre_trig, input int post_trig);
    return (addr_w >= 1) && (depth == (1 << addr_w)) &&
           (pre_trig >= 1) && (post_trig >= 1) &&
           (pre_trig + post_trig <= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_capture_buffer_sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture_buffer_sdp_ram
//  Description : Simple dual-port RAM, one write port and one read port with
//                a registered (1-cycle latency) read. Contents are not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_capture_buffer_sdp_ram
  import adc_capture_buffer_pkg::*;
#(
  parameter int DATA_W = c_default_data_w,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port: store the sample at the write address.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: registered read, data appears the cycle after i_re.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/adc_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture_buffer
//  Description : Captures the ADC stream into a circular RAM and, once a
//                trigger window is complete, replays it oldest-first as a
//                valid/ready stream framed with sop/eop.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_capture_buffer
  import adc_capture_buffer_pkg::*;
#(
  parameter int DATA_W    = c_default_data_w,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 10,
  parameter int PRE_TRIG  = 256,
  parameter int POST_TRIG = 768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              trigger,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              busy,
  output logic              done
);

  // Refuse to elaborate a configuration whose window cannot fit the RAM.
  if (!params_legal(DEPTH, ADDR_W, PRE_TRIG, POST_TRIG)) begin : g_param_check
    $error("adc_capture_buffer: illegal DEPTH/ADDR_W/PRE_TRIG/POST_TRIG");
  end

  localparam int              c_win       = PRE_TRIG + POST_TRIG;
  localparam logic [ADDR_W:0] c_depth_cnt = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_pre_cnt   = (ADDR_W+1)'(PRE_TRIG);
  localparam logic [ADDR_W:0] c_post_last = (ADDR_W+1)'(POST_TRIG - 1);
  localparam logic [ADDR_W:0] c_win_cnt   = (ADDR_W+1)'(c_win);
  localparam logic [ADDR_W:0] c_win_last  = (ADDR_W+1)'(c_win - 1);
  // Window length modulo DEPTH; a full-RAM window correctly becomes 0.
  localparam logic [ADDR_W-1:0] c_win_addr = ADDR_W'(c_win);

  state_t              r_state;
  state_t              w_state_next;

  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_fill_cnt;
  logic [ADDR_W:0]     r_post_cnt;
  logic [ADDR_W:0]     r_play_cnt;

  // Read in flight: RAM data is valid this cycle, tagged with its framing.
  logic                r_pend_valid;
  logic                r_pend_sop;
  logic                r_pend_eop;

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_sop;
  logic                r_out_eop;

  logic                r_skid_valid;
  logic [DATA_W-1:0]   r_skid_data;
  logic                r_skid_sop;
  logic                r_skid_eop;

  logic                r_done;

  logic                w_wr_en;
  logic [ADDR_W:0]     w_fill_next;
  logic                w_trig_ok;
  logic                w_post_done;
  logic                w_accept;
  logic                w_last_accept;
  logic [1:0]          w_occ;
  logic                w_rd_en;
  logic [DATA_W-1:0]   w_ram_q;

  assign w_wr_en       = ((r_state == c_st_pre) || (r_state == c_st_post)) && adc_valid;
  // Fill count including a write happening this cycle, saturating at DEPTH.
  assign w_fill_next   = (w_wr_en && (r_fill_cnt != c_depth_cnt)) ? (r_fill_cnt + 1'b1)
                                                                   : r_fill_cnt;
  assign w_trig_ok     = trigger && (w_fill_next >= c_pre_cnt);
  assign w_post_done   = adc_valid && (r_post_cnt == c_post_last);
  assign w_accept      = r_out_valid && out_ready;
  assign w_last_accept = w_accept && r_out_eop;
  // Samples held or in flight after this cycle's acceptance; the two output
  // stages can absorb at most two, so a new read is issued only below that.
  assign w_occ         = {1'b0, r_out_valid} + {1'b0, r_skid_valid}
                       + {1'b0, r_pend_valid} - {1'b0, w_accept};
  assign w_rd_en       = (r_state == c_st_play) && (r_play_cnt != c_win_cnt) && (w_occ < 2'd2);

  adc_capture_buffer_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sdp_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (adc_data),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: arm, accepted trigger, last post sample, eop accepted.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (arm)           w_state_next = c_st_pre;
      c_st_pre:  if (w_trig_ok)     w_state_next = c_st_post;
      c_st_post: if (w_post_done)   w_state_next = c_st_play;
      c_st_play: if (w_last_accept) w_state_next = c_st_idle;
      default:                      w_state_next = c_st_idle;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = (r_state != c_st_idle);
  end

  // Capture pointers/counters and the replay read pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_post_cnt <= '0;
      r_rd_ptr   <= '0;
      r_play_cnt <= '0;
    end else begin
      if ((r_state == c_st_idle) && arm) begin
        r_wr_ptr   <= '0;
        r_fill_cnt <= '0;
      end else if (w_wr_en) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_fill_cnt <= w_fill_next;
      end

      if ((r_state == c_st_pre) && w_trig_ok) begin
        r_post_cnt <= '0;
      end else if ((r_state == c_st_post) && adc_valid) begin
        r_post_cnt <= r_post_cnt + 1'b1;
      end

      // Oldest window sample sits one full window behind the next write slot.
      if ((r_state == c_st_post) && w_post_done) begin
        r_rd_ptr   <= r_wr_ptr + ADDR_W'(1) - c_win_addr;
        r_play_cnt <= '0;
      end else if (w_rd_en) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_play_cnt <= r_play_cnt + 1'b1;
      end
    end
  end

  // Track the read in flight and its sop/eop tag alongside the RAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend_sop   <= 1'b0;
      r_pend_eop   <= 1'b0;
    end else begin
      r_pend_valid <= w_rd_en;
      r_pend_sop   <= (r_play_cnt == '0);
      r_pend_eop   <= (r_play_cnt == c_win_last);
    end
  end

  // Output register with skid: refill from skid first, then from the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sop    <= 1'b0;
      r_out_eop    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_sop   <= 1'b0;
      r_skid_eop   <= 1'b0;
    end else if (!r_out_valid || w_accept) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_sop    <= r_skid_sop;
        r_out_eop    <= r_skid_eop;
        r_skid_valid <= r_pend_valid;
        r_skid_data  <= w_ram_q;
        r_skid_sop   <= r_pend_sop;
        r_skid_eop   <= r_pend_eop;
      end else if (r_pend_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_ram_q;
        r_out_sop    <= r_pend_sop;
        r_out_eop    <= r_pend_eop;
      end else begin
        r_out_valid  <= 1'b0;
        r_out_sop    <= 1'b0;
        r_out_eop    <= 1'b0;
      end
    end else if (r_pend_valid) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_ram_q;
      r_skid_sop   <= r_pend_sop;
      r_skid_eop   <= r_pend_eop;
    end
  end

  // One-cycle completion pulse after the last window sample is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last_accept;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sop   = r_out_sop;
  assign out_eop   = r_out_eop;
  assign done      = r_done;

endmodule
`default_nettype wire
